// File: rtl/rvfi_retire_pkg.sv
// Shared types for the RVFI retire buffer: the per-instruction payload carried
// from completion to retirement, and the rd_wdata rule applied at the port.
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

package rvfi_retire_pkg;

    localparam int XLEN    = `RISCV_FORMAL_XLEN;
    localparam int MASK_W  = XLEN / 8;
    localparam int ENTRY_W = 48 + 9 * XLEN + XLEN / 4;

    // Field order follows the rvfi_* output ports; spare pads the payload to ENTRY_W.
    typedef struct packed {
        logic [31:0]       insn;
        logic              trap;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
        logic [MASK_W-1:0] mem_rmask;
        logic [MASK_W-1:0] mem_wmask;
        logic [XLEN-1:0]   spare;
    } rvfi_entry_t;

    // x0 is never written, so the reported write data must read as zero.
    function automatic rvfi_entry_t rvfi_sanitize(input rvfi_entry_t e);
        rvfi_entry_t r;
        r          = e;
        r.rd_wdata = (e.rd_addr == 5'd0) ? {XLEN{1'b0}} : e.rd_wdata;
        return r;
    endfunction

endpackage

// File: rtl/rvfi_retire_chk.sv
// Simulation checks for the retire buffer's completion interface.
module rvfi_retire_chk (
    input logic clk,
    input logic resetn,
    input logic cmp_valid,
    input logic flush,
    input logic cmp_hit
);

    a_cmp_tag_in_flight: assert property (
        @(posedge clk) disable iff (!resetn) (cmp_valid && !flush) |-> cmp_hit
    );

endmodule

// File: rtl/rvfi_retire_ram.sv
// Payload store indexed by tag: completion writes, the head entry is read
// combinationally so retirement needs no extra cycle.
module rvfi_retire_ram
    import rvfi_retire_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_addr,
    input  rvfi_entry_t       wr_data,
    input  logic [TAG_W-1:0]  rd_addr,
    output rvfi_entry_t       rd_data
);

    rvfi_entry_t mem_r [DEPTH];

    // Completion write; contents are only trusted once the matching done bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/rvfi_retire_buffer.sv
// In-order retire stage: tags are allocated in program order, completed out of
// order, and retired one per cycle onto a single RVFI channel.
module rvfi_retire_buffer
    import rvfi_retire_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = $clog2(DEPTH),
    parameter int ORDER_W = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               cmp_valid,
    input  logic [TAG_W-1:0]   cmp_tag,
    input  logic [ENTRY_W-1:0] cmp_data,
    input  logic               flush,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [31:0]        rvfi_insn,
    output logic               rvfi_trap,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [XLEN-1:0]    rvfi_rs1_rdata,
    output logic [XLEN-1:0]    rvfi_rs2_rdata,
    output logic [XLEN-1:0]    rvfi_rd_wdata,
    output logic [XLEN-1:0]    rvfi_pc_rdata,
    output logic [XLEN-1:0]    rvfi_pc_wdata,
    output logic [XLEN-1:0]    rvfi_mem_addr,
    output logic [XLEN-1:0]    rvfi_mem_rdata,
    output logic [XLEN-1:0]    rvfi_mem_wdata,
    output logic [MASK_W-1:0]  rvfi_mem_rmask,
    output logic [MASK_W-1:0]  rvfi_mem_wmask
);

    localparam int                 PTR_W     = TAG_W + 1;
    localparam logic [PTR_W-1:0]   PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]   PTR_ONE   = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]   PTR_FULL  = {1'b1, {TAG_W{1'b0}}};
    localparam logic [ORDER_W-1:0] ORDER_ONE = {{(ORDER_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0]   BIT0      = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0]   NO_BITS   = {DEPTH{1'b0}};

    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W-1:0]   count_s;
    logic [TAG_W-1:0]   head_idx_s;
    logic [TAG_W-1:0]   tail_idx_s;
    logic [TAG_W-1:0]   cmp_rel_s;
    logic [DEPTH-1:0]   done_r;
    logic [DEPTH-1:0]   set_mask_s;
    logic [DEPTH-1:0]   clr_mask_s;
    logic [ORDER_W-1:0] order_cnt_r;
    logic               full_s;
    logic               alloc_fire_s;
    logic               cmp_hit_s;
    logic               cmp_fire_s;
    logic               retire_fire_s;
    rvfi_entry_t        head_entry_s;
    rvfi_entry_t        out_r;
    logic               rvfi_valid_r;
    logic [ORDER_W-1:0] rvfi_order_r;
    logic               unused_spare_s;

    assign head_idx_s = head_r[TAG_W-1:0];
    assign tail_idx_s = tail_r[TAG_W-1:0];
    assign count_s    = tail_r - head_r;
    assign full_s     = (count_s == PTR_FULL);

    // Readiness uses the start-of-cycle count, so a full buffer refuses even while retiring.
    assign alloc_ready  = !full_s && !flush;
    assign alloc_tag    = tail_idx_s;
    assign alloc_fire_s = alloc_valid && alloc_ready;

    // A completion counts only for tags in [head, tail), measured as distance from head.
    assign cmp_rel_s     = cmp_tag - head_idx_s;
    assign cmp_hit_s     = ({1'b0, cmp_rel_s} < count_s);
    assign cmp_fire_s    = cmp_valid && cmp_hit_s && !flush;
    assign retire_fire_s = (count_s != PTR_ZERO) && done_r[head_idx_s] && !flush;

    assign set_mask_s = cmp_fire_s ? (BIT0 << cmp_tag) : NO_BITS;
    assign clr_mask_s = (alloc_fire_s  ? (BIT0 << tail_idx_s) : NO_BITS)
                      | (retire_fire_s ? (BIT0 << head_idx_s) : NO_BITS);

    // Pointer, done-bit and order-counter bookkeeping; clears override sets on the same tag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_r      <= '0;
            tail_r      <= '0;
            done_r      <= '0;
            order_cnt_r <= '0;
        end else if (flush) begin
            tail_r <= head_r;
            done_r <= '0;
        end else begin
            if (alloc_fire_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (retire_fire_s) begin
                head_r      <= head_r + PTR_ONE;
                order_cnt_r <= order_cnt_r + ORDER_ONE;
            end
            done_r <= (done_r | set_mask_s) & ~clr_mask_s;
        end
    end

    rvfi_retire_ram #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (cmp_fire_s),
        .wr_addr (cmp_tag),
        .wr_data (rvfi_entry_t'(cmp_data)),
        .rd_addr (head_idx_s),
        .rd_data (head_entry_s)
    );

    // Registered RVFI port: loads on retire, otherwise only the valid pulse drops.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvfi_valid_r <= 1'b0;
            rvfi_order_r <= '0;
            out_r        <= '0;
        end else if (retire_fire_s) begin
            rvfi_valid_r <= 1'b1;
            rvfi_order_r <= order_cnt_r;
            out_r        <= rvfi_sanitize(head_entry_s);
        end else begin
            rvfi_valid_r <= 1'b0;
        end
    end

    assign rvfi_valid     = rvfi_valid_r;
    assign rvfi_order     = rvfi_order_r;
    assign rvfi_insn      = out_r.insn;
    assign rvfi_trap      = out_r.trap;
    assign rvfi_rs1_addr  = out_r.rs1_addr;
    assign rvfi_rs2_addr  = out_r.rs2_addr;
    assign rvfi_rd_addr   = out_r.rd_addr;
    assign rvfi_rs1_rdata = out_r.rs1_rdata;
    assign rvfi_rs2_rdata = out_r.rs2_rdata;
    assign rvfi_rd_wdata  = out_r.rd_wdata;
    assign rvfi_pc_rdata  = out_r.pc_rdata;
    assign rvfi_pc_wdata  = out_r.pc_wdata;
    assign rvfi_mem_addr  = out_r.mem_addr;
    assign rvfi_mem_rdata = out_r.mem_rdata;
    assign rvfi_mem_wdata = out_r.mem_wdata;
    assign rvfi_mem_rmask = out_r.mem_rmask;
    assign rvfi_mem_wmask = out_r.mem_wmask;
    assign unused_spare_s = ^out_r.spare;

    rvfi_retire_chk u_chk (
        .clk       (clk),
        .resetn    (resetn),
        .cmp_valid (cmp_valid),
        .flush     (flush),
        .cmp_hit   (cmp_hit_s)
    );

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Directed scenarios plus a randomized run against a queue-based model of the
// retire window for rvfi_retire_buffer.
module tb_rvfi_retire_buffer;
    import rvfi_retire_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TAG_W   = 3;
    localparam int ORDER_W = 64;
    localparam int OBS_W   = ENTRY_W - XLEN;

    typedef struct {
        bit          done;
        rvfi_entry_t pay;
    } slot_t;

    logic               clk = 1'b0;
    logic               resetn;
    logic               alloc_valid;
    logic               alloc_ready;
    logic [TAG_W-1:0]   alloc_tag;
    logic               cmp_valid;
    logic [TAG_W-1:0]   cmp_tag;
    logic [ENTRY_W-1:0] cmp_data;
    logic               flush;
    logic               rvfi_valid;
    logic [ORDER_W-1:0] rvfi_order;
    logic [31:0]        rvfi_insn;
    logic               rvfi_trap;
    logic [4:0]         rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [XLEN-1:0]    rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [XLEN-1:0]    rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [XLEN-1:0]    rvfi_mem_rdata, rvfi_mem_wdata;
    logic [MASK_W-1:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [OBS_W-1:0]   obs_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rvfi_retire_buffer #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
        .clk(clk), .resetn(resetn),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data), .flush(flush),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
        .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask)
    );

    assign obs_s = {rvfi_insn, rvfi_trap, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
                    rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata,
                    rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
                    rvfi_mem_rmask, rvfi_mem_wmask};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cmp_valid   = 1'b0;
        cmp_tag     = '0;
        cmp_data    = '0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    function automatic rvfi_entry_t rand_entry();
        logic [ENTRY_W-1:0] v;
        for (int k = 0; k < ENTRY_W; k++) v[k] = 1'($urandom_range(0, 1));
        return rvfi_entry_t'(v);
    endfunction

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if ({rvfi_valid, rvfi_order, obs_s} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b order=%0d insn=%h, want all zero",
                     rvfi_valid, rvfi_order, rvfi_insn);
        end
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL reset_alloc: got ready=%0b tag=%0d, want ready=1 tag=0", alloc_ready, alloc_tag);
        end
    endtask

    task automatic test_in_order();
        rvfi_entry_t p [3];
        int ctag [6] = '{2, 0, 1, -1, -1, -1};
        bit ev   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            p[i]      = rand_entry();
            p[i].insn = 32'h1000_0000 + 32'(i);
            alloc_valid = 1'b1;
            settle();
            checks++;
            if (alloc_tag !== TAG_W'(i)) begin
                failures++;
                $display("FAIL inorder_alloc_tag: got %0d, want %0d", alloc_tag, i);
            end
            tick();
        end
        alloc_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ctag[c] >= 0) begin
                cmp_valid = 1'b1;
                cmp_tag   = TAG_W'(ctag[c]);
                cmp_data  = p[ctag[c]];
            end else begin
                cmp_valid = 1'b0;
            end
            tick();
            checks++;
            if (rvfi_valid !== ev[c]) begin
                failures++;
                $display("FAIL inorder_valid[%0d]: got %0b, want %0b", c, rvfi_valid, ev[c]);
            end
            if (ev[c]) begin
                checks++;
                if (rvfi_order !== 64'(c - 2) || rvfi_insn !== p[c - 2].insn) begin
                    failures++;
                    $display("FAIL inorder_retire[%0d]: got order=%0d insn=%h, want order=%0d insn=%h",
                             c, rvfi_order, rvfi_insn, c - 2, p[c - 2].insn);
                end
            end
        end
        idle();
    endtask

    task automatic test_full_wrap();
        rvfi_entry_t q;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1;
            tick();
        end
        q = rand_entry();
        q.insn = 32'h2000_0000;
        alloc_valid = 1'b0;
        cmp_valid = 1'b1;
        cmp_tag   = 3'd0;
        cmp_data  = q;
        settle();
        checks++;
        if (alloc_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: got %0b, want 0", alloc_ready);
        end
        tick();
        cmp_valid   = 1'b0;
        alloc_valid = 1'b1;
        settle();
        checks++;
        if (alloc_ready !== 1'b0 || rvfi_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_retire_cycle: got ready=%0b valid=%0b, want ready=0 valid=0", alloc_ready, rvfi_valid);
        end
        tick();
        settle();
        checks++;
        if (rvfi_valid !== 1'b1 || rvfi_order !== 64'd0 || rvfi_insn !== q.insn) begin
            failures++;
            $display("FAIL full_retire_out: got valid=%0b order=%0d insn=%h, want 1 0 %h",
                     rvfi_valid, rvfi_order, rvfi_insn, q.insn);
        end
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL full_wrap_alloc: got ready=%0b tag=%0d, want ready=1 tag=0", alloc_ready, alloc_tag);
        end
        tick();
        alloc_valid = 1'b0;
        settle();
        checks++;
        if (alloc_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_again: got ready=%0b, want 0", alloc_ready);
        end
        idle();
    endtask

    task automatic test_flush();
        rvfi_entry_t e0, e1;
        e0 = rand_entry(); e0.insn = 32'h3000_0000;
        e1 = rand_entry(); e1.insn = 32'h3000_0001;
        do_reset();
        alloc_valid = 1'b1; tick(); alloc_valid = 1'b0;
        cmp_valid = 1'b1; cmp_tag = 3'd0; cmp_data = e0; tick();
        cmp_valid = 1'b0; tick();
        checks++;
        if (rvfi_valid !== 1'b1 || rvfi_order !== 64'd0) begin
            failures++;
            $display("FAIL flush_pre_retire: got valid=%0b order=%0d, want 1 0", rvfi_valid, rvfi_order);
        end
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; tick();
        end
        alloc_valid = 1'b0;
        for (int t = 2; t <= 4; t++) begin
            cmp_valid = 1'b1; cmp_tag = TAG_W'(t); cmp_data = rand_entry(); tick();
            checks++;
            if (rvfi_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_early_retire[%0d]: got valid=%0b, want 0", t, rvfi_valid);
            end
        end
        cmp_valid = 1'b1; cmp_tag = 3'd1; cmp_data = rand_entry();
        alloc_valid = 1'b1; flush = 1'b1;
        settle();
        checks++;
        if (alloc_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: got %0b, want 0", alloc_ready);
        end
        tick();
        idle();
        settle();
        checks++;
        if (rvfi_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd1) begin
            failures++;
            $display("FAIL flush_after: got valid=%0b ready=%0b tag=%0d, want 0 1 1", rvfi_valid, alloc_ready, alloc_tag);
        end
        alloc_valid = 1'b1; tick(); alloc_valid = 1'b0; tick();
        checks++;
        if (rvfi_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_stale_done: got valid=%0b, want 0", rvfi_valid);
        end
        cmp_valid = 1'b1; cmp_tag = 3'd1; cmp_data = e1; tick();
        cmp_valid = 1'b0; tick();
        checks++;
        if (rvfi_valid !== 1'b1 || rvfi_order !== 64'd1 || rvfi_insn !== e1.insn) begin
            failures++;
            $display("FAIL flush_next_order: got valid=%0b order=%0d insn=%h, want 1 1 %h",
                     rvfi_valid, rvfi_order, rvfi_insn, e1.insn);
        end
        idle();
    endtask

    task automatic test_rd_zero();
        rvfi_entry_t e;
        e = rand_entry();
        e.rd_addr  = 5'd0;
        e.rd_wdata = XLEN'(32'hDEADBEEF);
        alloc_valid = 1'b1;
        settle();
        checks++;
        if (alloc_tag !== 3'd2) begin
            failures++;
            $display("FAIL rdzero_tag: got %0d, want 2", alloc_tag);
        end
        tick();
        alloc_valid = 1'b0;
        cmp_valid = 1'b1; cmp_tag = 3'd2; cmp_data = e; tick();
        cmp_valid = 1'b0; tick();
        checks++;
        if (rvfi_valid !== 1'b1 || rvfi_rd_addr !== 5'd0 || rvfi_rd_wdata !== '0 || rvfi_insn !== e.insn) begin
            failures++;
            $display("FAIL rdzero_wdata: got valid=%0b rd_addr=%0d rd_wdata=%h, want 1 0 0",
                     rvfi_valid, rvfi_rd_addr, rvfi_rd_wdata);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int order [4] = '{1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; tick();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmp_valid = 1'b1; cmp_tag = TAG_W'(order[i]); cmp_data = rand_entry(); tick();
        end
        cmp_valid = 1'b0;
        tick();
        checks++;
        if (rvfi_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got valid=%0b, want 1", rvfi_valid);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        checks++;
        if ({rvfi_valid, rvfi_order, obs_s} !== '0 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            failures++;
            $display("FAIL midreset_state: got valid=%0b order=%0d insn=%h ready=%0b tag=%0d, want zeros ready=1 tag=0",
                     rvfi_valid, rvfi_order, rvfi_insn, alloc_ready, alloc_tag);
        end
        tick();
        checks++;
        if (rvfi_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_retire: got valid=%0b, want 0", rvfi_valid);
        end
    endtask

    task automatic test_random();
        slot_t              win [$];
        int                 m_head;
        int                 ci;
        logic [ORDER_W-1:0] m_order, e_order;
        bit                 e_valid, ret, exp_ready, busy;
        rvfi_entry_t        e_last, retpay;
        logic [ENTRY_W-1:0] ev;
        do_reset();
        m_head = 0; m_order = '0; e_order = '0; e_valid = 1'b0; e_last = '0; retpay = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            busy        = ((cyc / 256) % 2) == 1;
            flush       = ($urandom_range(0, 63) == 0);
            alloc_valid = ($urandom_range(0, 7) < (busy ? 7 : 3));
            cmp_valid   = 1'b0; cmp_tag = '0; cmp_data = '0; ci = -1;
            if (win.size() > 0 && $urandom_range(0, 7) < (busy ? 3 : 6)) begin
                ci = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, win.size() - 1);
                cmp_valid = 1'b1;
                cmp_tag   = TAG_W'((m_head + ci) % DEPTH);
                cmp_data  = rand_entry();
            end
            exp_ready = (win.size() < DEPTH) && !flush;
            settle();
            checks++;
            if (alloc_ready !== exp_ready || alloc_tag !== TAG_W'((m_head + win.size()) % DEPTH)) begin
                failures++;
                $display("FAIL rand_alloc@%0d: got ready=%0b tag=%0d, want ready=%0b tag=%0d",
                         cyc, alloc_ready, alloc_tag, exp_ready, (m_head + win.size()) % DEPTH);
            end
            ret = 1'b0;
            if (flush) begin
                win.delete();
            end else begin
                ret = (win.size() > 0) && win[0].done;
                if (ret) retpay = win[0].pay;
                if (ci >= 0) begin
                    win[ci].done = 1'b1;
                    win[ci].pay  = cmp_data;
                end
                if (ret) begin
                    void'(win.pop_front());
                    m_head++;
                    e_order = m_order;
                    m_order = m_order + 64'd1;
                    e_last  = retpay;
                    if (e_last.rd_addr == 5'd0) e_last.rd_wdata = '0;
                end
                if (alloc_valid && exp_ready) win.push_back('{done: 1'b0, pay: '0});
            end
            e_valid = ret;
            tick();
            checks++;
            if (rvfi_valid !== e_valid) begin
                failures++;
                $display("FAIL rand_valid@%0d: got %0b, want %0b", cyc, rvfi_valid, e_valid);
            end
            checks++;
            if (rvfi_order !== e_order) begin
                failures++;
                $display("FAIL rand_order@%0d: got %0d, want %0d", cyc, rvfi_order, e_order);
            end
            ev = e_last;
            checks++;
            if (obs_s !== ev[ENTRY_W-1:XLEN]) begin
                failures++;
                $display("FAIL rand_payload@%0d: got %h, want %h", cyc, obs_s, ev[ENTRY_W-1:XLEN]);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        tick();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_flush();
        test_rd_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
